// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port and a data port.
// Optional round-robin tie-break for simultaneous requests: define MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: a requester raises req and holds it (with stable intent) until its
  // ready strobe; ready is a one-cycle combinational pulse in the final access cycle,
  // and the request is considered consumed at the end of that cycle.

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               final_cycle;
  logic               pick_data;
  logic               grant_fetch;
  logic               grant_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic               last_data_q, last_data_d;
`endif

  assign final_cycle = (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pick_data   = 1'b0;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie, serve whoever did not win the previous idle arbitration.
        if (if_req && d_req) pick_data = ~last_data_q;
        else                 pick_data = d_req;
        if (if_req || d_req) last_data_d = pick_data;
`else
        pick_data = d_req;
`endif
        if (pick_data)   grant_data  = 1'b1;
        else if (if_req) grant_fetch = 1'b1;
      end

      ST_FETCH: begin
        mem_re = 1'b1;
        if (final_cycle) begin
          if_ready   = 1'b1;
          if_rdata_d = mem_rdata;
          if (d_req) grant_data = 1'b1;
          else       state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DATA: begin
        mem_re = ~we_q;
        if (final_cycle) begin
          d_ready = 1'b1;
          mem_we  = we_q;
          if (!we_q) d_rdata_d = mem_rdata;
          if (if_req) grant_fetch = 1'b1;
          else        state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A grant, from IDLE or chained off a finishing access, latches the new command.
    if (grant_fetch) begin
      state_d = ST_FETCH;
      cnt_d   = WAIT_INIT;
      addr_d  = if_addr;
    end
    if (grant_data) begin
      state_d = ST_DATA;
      cnt_d   = WAIT_INIT;
      addr_d  = d_addr;
      wdata_d = d_wdata;
      we_d    = d_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Read data is forwarded in the ready cycle and held from the capture register after.
  assign if_rdata  = if_ready ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_ready && !we_q) ? mem_rdata : d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  a_one_ready: assert property (@(posedge clk) disable iff (!reset)
    !(if_ready && d_ready));
  a_no_re_we: assert property (@(posedge clk) disable iff (!reset)
    !(mem_re && mem_we));
  a_we_final: assert property (@(posedge clk) disable iff (!reset)
    mem_we |-> (state_q == ST_DATA && cnt_q == 4'd0));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT_CYCLES 0, 1, 2) driven by directed
// vectors; expectations are queued by the driver and checked by a negedge monitor.
module tb_mem_port_arbiter;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  localparam logic [3:0] P_IF_RDATA  = 4'd0;
  localparam logic [3:0] P_D_RDATA   = 4'd1;
  localparam logic [3:0] P_MEM_RE    = 4'd2;
  localparam logic [3:0] P_MEM_WE    = 4'd3;
  localparam logic [3:0] P_MEM_ADDR  = 4'd4;
  localparam logic [3:0] P_MEM_WDATA = 4'd5;
  localparam logic [3:0] P_STATE     = 4'd6;
  localparam logic [3:0] P_IF_READY  = 4'd7;
  localparam logic [3:0] P_D_READY   = 4'd8;
  localparam logic [3:0] P_RE_CNT    = 4'd9;
  localparam logic [3:0] P_WE_CNT    = 4'd10;
  localparam logic [3:0] P_QSIZE     = 4'd11;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  inst;
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] hold;
  } exp_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [1:0]  inst;
    logic [31:0] expv;
  } probe_t;

  logic        clk;
  logic        reset;
  logic        mem_noise;
  logic [31:0] cyc = 32'd0;

  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic [31:0] if_rdata  [3];
  logic        if_ready  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [31:0] d_rdata   [3];
  logic        d_ready   [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        mem_re    [3];
  logic        mem_we    [3];
  logic [31:0] mem_rdata [3];
  logic        stall     [3];
  logic [1:0]  dbg_state [3];

  exp_t   exp_q[$];
  probe_t probe_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     re_cnt[3];
  int     we_cnt[3];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h8C22_0004;
    return {16'hC0DE, a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.WAIT_CYCLES(g), .ADDR_W(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ready  (if_ready[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_ready   (d_ready[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_re    (mem_re[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g]),
      .stall     (stall[g]),
      .dbg_state (dbg_state[g])
    );
    assign mem_rdata[g] = mem_noise ? 32'hBAD0_0000 : mem_model(mem_addr[g]);
  end

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input int g, input logic [31:0] c,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] h);
    exp_t e;
    e.kind = kind;
    e.inst = 2'(g);
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    e.hold = h;
    exp_q.push_back(e);
  endtask

  task automatic probe(input logic [3:0] code, input int g, input logic [31:0] v);
    probe_t p;
    p.code = code;
    p.inst = 2'(g);
    p.expv = v;
    probe_q.push_back(p);
  endtask

  task automatic wait_ready(input int g, input bit is_d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? d_ready[g] : if_ready[g]) break;
    end
  endtask

  // Simultaneous fetch + load on the WAIT_CYCLES=1 instance.
  task automatic pair(input logic [31:0] ia, input logic [31:0] da, input bit fetch_first);
    logic [31:0] c;
    logic        ir;
    logic        dr;
    c = cyc;
    if_req[1]  = 1'b1;
    if_addr[1] = ia;
    d_req[1]   = 1'b1;
    d_we[1]    = 1'b0;
    d_addr[1]  = da;
    if (fetch_first) begin
      push(K_FETCH, 1, c + 32'd2, ia, {16'hC0DE, ia[15:0]}, 32'd0);
      push(K_LOAD,  1, c + 32'd4, da, {16'hC0DE, da[15:0]}, 32'd0);
    end else begin
      push(K_LOAD,  1, c + 32'd2, da, {16'hC0DE, da[15:0]}, 32'd0);
      push(K_FETCH, 1, c + 32'd4, ia, {16'hC0DE, ia[15:0]}, 32'd0);
    end
    for (int i = 0; i < 20 && (if_req[1] || d_req[1]); i++) begin
      @(negedge clk);
      ir = if_ready[1];
      dr = d_ready[1];
      tick();
      if (ir) if_req[1] = 1'b0;
      if (dr) d_req[1]  = 1'b0;
    end
    if_req[1] = 1'b0;
    d_req[1]  = 1'b0;
  endtask

  // Scoreboard / monitor
  function automatic string pname(input logic [3:0] code);
    case (code)
      P_IF_RDATA:  return "if_rdata";
      P_D_RDATA:   return "d_rdata";
      P_MEM_RE:    return "mem_re";
      P_MEM_WE:    return "mem_we";
      P_MEM_ADDR:  return "mem_addr";
      P_MEM_WDATA: return "mem_wdata";
      P_STATE:     return "state";
      P_IF_READY:  return "if_ready";
      P_D_READY:   return "d_ready";
      P_RE_CNT:    return "mem_re_cycles";
      P_WE_CNT:    return "mem_we_cycles";
      P_QSIZE:     return "pending_expectations";
      default:     return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] probe_val(input logic [3:0] code, input int g);
    case (code)
      P_IF_RDATA:  return if_rdata[g];
      P_D_RDATA:   return d_rdata[g];
      P_MEM_RE:    return 32'(mem_re[g]);
      P_MEM_WE:    return 32'(mem_we[g]);
      P_MEM_ADDR:  return mem_addr[g];
      P_MEM_WDATA: return mem_wdata[g];
      P_STATE:     return 32'(dbg_state[g]);
      P_IF_READY:  return 32'(if_ready[g]);
      P_D_READY:   return 32'(d_ready[g]);
      P_RE_CNT:    return 32'(re_cnt[g]);
      P_WE_CNT:    return 32'(we_cnt[g]);
      P_QSIZE:     return 32'(exp_q.size());
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, g, cyc, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t   e;
    probe_t p;
    logic   front_ok;
    logic   exp_we;
    for (int g = 0; g < 3; g++) begin
      re_cnt[g] = 0;
      we_cnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        chk(pname(p.code), int'(p.inst), probe_val(p.code, int'(p.inst)), p.expv);
      end
      for (int g = 0; g < 3; g++) begin
        if (mem_re[g]) re_cnt[g]++;
        if (mem_we[g]) we_cnt[g]++;
        chk("stall", g, 32'(stall[g]),
            32'((if_req[g] & ~if_ready[g]) | (d_req[g] & ~d_ready[g])));
        front_ok = (exp_q.size() > 0) && (int'(exp_q[0].inst) == g);
        e = front_ok ? exp_q[0] : '0;
        if (mem_re[g] || mem_we[g]) begin
          if (!front_ok) chk("unexpected_access", g, 32'(mem_re[g] | mem_we[g]), 32'd0);
          else           chk("mem_addr", g, mem_addr[g], e.addr);
        end
        exp_we = front_ok && (e.kind == K_STORE) && (e.cyc == cyc);
        chk("mem_we", g, 32'(mem_we[g]), 32'(exp_we));
        if (front_ok && e.kind == K_STORE) chk("mem_re_on_store", g, 32'(mem_re[g]), 32'd0);
        if (if_ready[g] || d_ready[g]) begin
          if (!front_ok) begin
            chk("unexpected_ready", g, 32'(if_ready[g] | d_ready[g]), 32'd0);
          end else begin
            void'(exp_q.pop_front());
            chk("ready_cycle", g, cyc, e.cyc);
            chk("if_ready", g, 32'(if_ready[g]), 32'(e.kind == K_FETCH));
            chk("d_ready", g, 32'(d_ready[g]), 32'(e.kind != K_FETCH));
            case (e.kind)
              K_FETCH: chk("if_rdata", g, if_rdata[g], e.data);
              K_LOAD:  chk("d_rdata", g, d_rdata[g], e.data);
              default: begin
                chk("mem_wdata", g, mem_wdata[g], e.data);
                chk("d_rdata_on_store", g, d_rdata[g], e.hold);
              end
            endcase
          end
        end else if (front_ok && cyc > e.cyc) begin
          chk("ready_late", g, cyc, e.cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Directed stimulus
  initial begin : driver
    logic [31:0] c0;
    logic [31:0] r;
    int          base_re;
    int          base_we;
    bit          rr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    reset     = 1'b0;
    mem_noise = 1'b0;
    for (int g = 0; g < 3; g++) begin
      if_req[g]  = 1'b0;
      if_addr[g] = 32'd0;
      d_req[g]   = 1'b0;
      d_we[g]    = 1'b0;
      d_addr[g]  = 32'd0;
      d_wdata[g] = 32'd0;
    end
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      probe(P_STATE, g, 32'd0);
      probe(P_MEM_RE, g, 32'd0);
      probe(P_IF_RDATA, g, 32'd0);
      probe(P_D_RDATA, g, 32'd0);
      probe(P_MEM_ADDR, g, 32'd0);
    end
    tick();
    reset = 1'b1;
    tick();

    // Lone fetch, 2 wait states; address change mid-access must be ignored.
    tick();
    c0 = cyc;
    base_re = re_cnt[2];
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h0000_0100;
    push(K_FETCH, 2, c0 + 32'd3, 32'h0000_0100, 32'h8C22_0004, 32'd0);
    tick();
    if_addr[2] = 32'h0000_0999;
    wait_ready(2, 1'b0);
    tick();
    if_req[2] = 1'b0;
    mem_noise = 1'b1;
    probe(P_IF_RDATA, 2, 32'h8C22_0004);
    probe(P_RE_CNT, 2, 32'(base_re + 3));
    probe(P_STATE, 2, 32'd0);
    probe(P_MEM_RE, 2, 32'd0);
    tick();
    probe(P_IF_RDATA, 2, 32'h8C22_0004);
    tick();
    mem_noise = 1'b0;

    // Two simultaneous request pairs separated by IDLE.
    tick();
    pair(32'h0000_0200, 32'h0000_0040, rr);
    tick();
    tick();
    pair(32'h0000_0204, 32'h0000_0044, 1'b0);
    mem_noise = 1'b1;
    probe(P_D_RDATA, 1, 32'hC0DE_0044);
    probe(P_IF_RDATA, 1, 32'hC0DE_0204);
    probe(P_STATE, 1, 32'd0);
    tick();
    mem_noise = 1'b0;

    // Store: single mem_we pulse, load data untouched; mid-access changes ignored.
    tick();
    c0 = cyc;
    base_we = we_cnt[1];
    d_req[1]   = 1'b1;
    d_we[1]    = 1'b1;
    d_addr[1]  = 32'h0000_0020;
    d_wdata[1] = 32'hDEAD_BEEF;
    push(K_STORE, 1, c0 + 32'd2, 32'h0000_0020, 32'hDEAD_BEEF, 32'hC0DE_0044);
    tick();
    d_addr[1]  = 32'h0000_0024;
    d_wdata[1] = 32'h1234_5678;
    wait_ready(1, 1'b1);
    tick();
    d_req[1]  = 1'b0;
    d_we[1]   = 1'b0;
    mem_noise = 1'b1;
    probe(P_WE_CNT, 1, 32'(base_we + 1));
    probe(P_D_RDATA, 1, 32'hC0DE_0044);
    probe(P_MEM_WE, 1, 32'd0);
    tick();
    mem_noise = 1'b0;

    // Reset in the middle of a store, then a fetch pending at release.
    tick();
    c0 = cyc;
    base_we = we_cnt[2];
    d_req[2]   = 1'b1;
    d_we[2]    = 1'b1;
    d_addr[2]  = 32'h0000_0080;
    d_wdata[2] = 32'hCAFE_F00D;
    tick();
    #2;
    reset = 1'b0;
    probe(P_IF_RDATA, 2, 32'd0);
    probe(P_D_RDATA, 2, 32'd0);
    probe(P_MEM_RE, 2, 32'd0);
    probe(P_MEM_WE, 2, 32'd0);
    probe(P_MEM_ADDR, 2, 32'd0);
    probe(P_MEM_WDATA, 2, 32'd0);
    probe(P_IF_READY, 2, 32'd0);
    probe(P_D_READY, 2, 32'd0);
    probe(P_STATE, 2, 32'd0);
    probe(P_D_RDATA, 1, 32'd0);
    d_req[2]   = 1'b0;
    d_we[2]    = 1'b0;
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h0000_0300;
    tick();
    tick();
    reset = 1'b1;
    r = cyc;
    push(K_FETCH, 2, r + 32'd3, 32'h0000_0300, 32'hC0DE_0300, 32'd0);
    tick();
    probe(P_STATE, 2, 32'd1);
    wait_ready(2, 1'b0);
    tick();
    if_req[2] = 1'b0;
    probe(P_WE_CNT, 2, 32'(base_we));
    tick();

    // Zero wait states, back-to-back fetches with a fresh address after each ready.
    tick();
    c0 = cyc;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0000;
    push(K_FETCH, 0, c0 + 32'd1, 32'h0000_0000, 32'hC0DE_0000, 32'd0);
    push(K_FETCH, 0, c0 + 32'd3, 32'h0000_0004, 32'hC0DE_0004, 32'd0);
    push(K_FETCH, 0, c0 + 32'd5, 32'h0000_0008, 32'hC0DE_0008, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_ready(0, 1'b0);
      tick();
      if (k < 2) if_addr[0] = if_addr[0] + 32'd4;
      else       if_req[0]  = 1'b0;
    end

    tick();
    probe(P_QSIZE, 0, 32'd0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
